// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared funct3 encodings and responder state type
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    // Stores only have signed-width encodings; loads also allow the unsigned ones.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 inside {F3_B, F3_H, F3_W};
        end
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and load extraction/extension
module dmem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: begin
                byte_en    = 4'b0000;
                wdata_lane = 32'h0;
            end
        endcase
    end

    always_comb begin
        byte_v = 8'h0;
        case (addr_lo)
            2'd0:    byte_v = rword[7:0];
            2'd1:    byte_v = rword[15:8];
            2'd2:    byte_v = rword[23:16];
            default: byte_v = rword[31:24];
        endcase
        half_v = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        rdata_ext = 32'h0;
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_v[7]}}, byte_v};
            F3_BU:   rdata_ext = {24'h0, byte_v};
            F3_H:    rdata_ext = {{16{half_v[15]}}, half_v};
            F3_HU:   rdata_ext = {16'h0, half_v};
            F3_W:    rdata_ext = rword;
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory responder with fixed wait states
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    mem_state_e  state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_f3;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [2:0]  acc_f3;
    logic [IDX_W-1:0] acc_idx;
    logic        in_range;
    logic        acc_err;
    logic        exec;

    logic [31:0] rword;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_ext;
    logic        misaligned;

    // With zero wait states the access runs on the capture edge, so use the live request.
    always_comb begin
        acc_we    = cap_we;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        acc_f3    = cap_f3;
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_f3    = req_funct3;
        end
    end

    assign acc_idx  = acc_addr[IDX_W+1:2];
    assign in_range = ((acc_addr[31:2] >> IDX_W) == 30'd0);
    assign acc_err  = misaligned | ~in_range | ~funct3_legal(acc_we, acc_f3);
    assign rword    = mem[acc_idx];

    assign exec = rst_n &&
                  (((state == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                   ((state == WAIT) && (cnt == 4'd1)));

    assign req_ready = (state == IDLE);
    assign stall     = ((state == IDLE) && req_valid) || (state == WAIT);

    dmem_lane_align u_lane_align (
        .addr_lo    (acc_addr[1:0]),
        .funct3     (acc_f3),
        .wdata      (acc_wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned)
    );

    // The array is deliberately left unreset; only the controller is cleared.
    always_ff @(posedge clk) begin
        if (exec && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[acc_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_addr   <= 32'h0;
            cap_wdata  <= 32'h0;
            cap_f3     <= 3'b000;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (exec) begin
                resp_valid <= 1'b1;
                resp_rdata <= (acc_err || acc_we) ? 32'h0 : rdata_ext;
                resp_err   <= acc_err;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_f3    <= req_funct3;
                        cnt       <= 4'(WAIT_STATES);
                        state     <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at 2 and 0 wait states
module tb_dmem_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_err;
    } acc_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rv2, rv0;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;

    logic        ready2, resp_valid2, err2, stall2;
    logic [31:0] rdata2;
    logic        ready0, resp_valid0, err0, stall0;
    logic [31:0] rdata0;

    logic        sel0;
    logic        s_resp_valid, s_err, s_stall, s_ready;
    logic [31:0] s_rdata;

    exp_t        exp_q[$];
    int          checks;
    int          failures;
    int          obs_lat, obs_stall;
    logic [31:0] obs_rd;
    logic        obs_err, obs_ready_resp, obs_stall_resp;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(ready2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid2), .resp_rdata(rdata2), .resp_err(err2), .stall(stall2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid0), .resp_rdata(rdata0), .resp_err(err0), .stall(stall0)
    );

    assign s_resp_valid = sel0 ? resp_valid0 : resp_valid2;
    assign s_rdata      = sel0 ? rdata0 : rdata2;
    assign s_err        = sel0 ? err0 : err2;
    assign s_stall      = sel0 ? stall0 : stall2;
    assign s_ready      = sel0 ? ready0 : ready2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input bit use0, input acc_t a);
        sel0 = use0;
        @(posedge clk); #1;
        req_we = a.we; req_addr = a.addr; req_wdata = a.wdata; req_funct3 = a.f3;
        if (use0) rv0 = 1'b1; else rv2 = 1'b1;
        obs_lat = -1; obs_stall = 0; obs_ready_resp = 1'bx; obs_stall_resp = 1'bx;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_resp_valid) begin
                obs_lat = c; obs_rd = s_rdata; obs_err = s_err;
                obs_ready_resp = s_ready; obs_stall_resp = s_stall;
                break;
            end
            if (s_stall) obs_stall++;
        end
        @(posedge clk); #1;
        rv0 = 1'b0; rv2 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rv2 = 1'b1; rv0 = 1'b0; sel0 = 1'b0;
        req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'b010;
        @(negedge clk); @(negedge clk);
        checks++;
        if (resp_valid2 !== 1'b0 || rdata2 !== 32'h0 || err2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs valid=%b rdata=%h err=%b required 0/00000000/0", resp_valid2, rdata2, err2);
        end
        checks++;
        if (ready2 !== 1'b1 || stall2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_stall ready=%b stall=%b required 1/1", ready2, stall2);
        end
        rv2 = 1'b0; #1;
        checks++;
        if (stall2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall_idle stall=%b required 0", stall2);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_word();
        acc_t tbl[$];
        exp_t e;
        tbl.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0});
        foreach (tbl[i]) begin
            exp_q.push_back({tbl[i].exp_err, tbl[i].exp_rd});
            issue(1'b0, tbl[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_rd !== e.rd || obs_err !== e.err || obs_lat != 3 || obs_stall != 3) begin
                failures++;
                $display("FAIL word[%0d] rdata=%h err=%b lat=%0d stall=%0d required %h/%b/3/3",
                         i, obs_rd, obs_err, obs_lat, obs_stall, e.rd, e.err);
            end
            checks++;
            if (obs_ready_resp !== 1'b0 || obs_stall_resp !== 1'b0) begin
                failures++;
                $display("FAIL word_resp_cycle[%0d] ready=%b stall=%b required 0/0", i, obs_ready_resp, obs_stall_resp);
            end
        end
    endtask

    task automatic test_subword();
        acc_t tbl[$];
        exp_t e;
        tbl.push_back('{1'b1, 32'h11, 32'h00000080, 3'b000, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0});
        tbl.push_back('{1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0});
        tbl.push_back('{1'b0, 32'h11, 32'h0, 3'b100, 32'h00000080, 1'b0});
        tbl.push_back('{1'b1, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0});
        tbl.push_back('{1'b1, 32'h22, 32'h00008001, 3'b001, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF8001, 1'b0});
        tbl.push_back('{1'b0, 32'h22, 32'h0, 3'b101, 32'h00008001, 1'b0});
        tbl.push_back('{1'b0, 32'h23, 32'h0, 3'b001, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h21, 32'h0000FFFF, 3'b001, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h20, 32'h0, 3'b010, 32'h80010000, 1'b0});
        foreach (tbl[i]) begin
            exp_q.push_back({tbl[i].exp_err, tbl[i].exp_rd});
            issue(1'b0, tbl[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_rd !== e.rd || obs_err !== e.err || obs_lat != 3) begin
                failures++;
                $display("FAIL subword[%0d] rdata=%h err=%b lat=%0d required %h/%b/3",
                         i, obs_rd, obs_err, obs_lat, e.rd, e.err);
            end
        end
    endtask

    task automatic test_errors();
        acc_t tbl[$];
        exp_t e;
        tbl.push_back('{1'b1, 32'h1000, 32'h12345678, 3'b010, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'hFFC, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0});
        tbl.push_back('{1'b0, 32'hFFC, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'b110, 32'h0, 1'b1});
        tbl.push_back('{1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1});
        tbl.push_back('{1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0});
        foreach (tbl[i]) begin
            exp_q.push_back({tbl[i].exp_err, tbl[i].exp_rd});
            issue(1'b0, tbl[i]);
            e = exp_q.pop_front();
            checks++;
            if (obs_rd !== e.rd || obs_err !== e.err || obs_lat != 3) begin
                failures++;
                $display("FAIL errors[%0d] rdata=%h err=%b lat=%0d required %h/%b/3",
                         i, obs_rd, obs_err, obs_lat, e.rd, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        acc_t a;
        exp_t e;
        int   stray;
        a = '{1'b1, 32'h30, 32'h11111111, 3'b010, 32'h0, 1'b0};
        issue(1'b0, a);
        a = '{1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0};
        exp_q.push_back({a.exp_err, a.exp_rd});
        issue(1'b0, a);
        e = exp_q.pop_front();
        checks++;
        if (obs_rd !== e.rd || obs_err !== e.err) begin
            failures++;
            $display("FAIL pre_reset_load rdata=%h err=%b required %h/%b", obs_rd, obs_err, e.rd, e.err);
        end
        sel0 = 1'b0;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h22222222; req_funct3 = 3'b010; rv2 = 1'b1;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0; rv2 = 1'b0; #1;
        checks++;
        if (resp_valid2 !== 1'b0 || rdata2 !== 32'h0 || err2 !== 1'b0 || ready2 !== 1'b1 || stall2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid valid=%b rdata=%h err=%b ready=%b stall=%b required 0/00000000/0/1/0",
                     resp_valid2, rdata2, err2, ready2, stall2);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid2) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_no_resp count=%0d required 0", stray);
        end
        a = '{1'b0, 32'h30, 32'h0, 3'b010, 32'h11111111, 1'b0};
        exp_q.push_back({a.exp_err, a.exp_rd});
        issue(1'b0, a);
        e = exp_q.pop_front();
        checks++;
        if (obs_rd !== e.rd || obs_err !== e.err || obs_lat != 3) begin
            failures++;
            $display("FAIL reset_dropped_store rdata=%h err=%b lat=%0d required %h/%b/3", obs_rd, obs_err, obs_lat, e.rd, e.err);
        end
    endtask

    task automatic test_back_to_back();
        acc_t st[$];
        acc_t ld[$];
        exp_t e;
        logic [5:0] resp_pat, ready_pat;
        int   idx;
        st.push_back('{1'b1, 32'h0, 32'h01020304, 3'b010, 32'h0, 1'b0});
        st.push_back('{1'b1, 32'h4, 32'h000000F0, 3'b010, 32'h0, 1'b0});
        st.push_back('{1'b1, 32'h8, 32'h0000ABCD, 3'b010, 32'h0, 1'b0});
        foreach (st[i]) begin
            issue(1'b1, st[i]);
            checks++;
            if (obs_lat != 1 || obs_err !== 1'b0) begin
                failures++;
                $display("FAIL w0_store[%0d] lat=%0d err=%b required 1/0", i, obs_lat, obs_err);
            end
        end
        ld.push_back('{1'b0, 32'h0, 32'h0, 3'b010, 32'h01020304, 1'b0});
        ld.push_back('{1'b0, 32'h4, 32'h0, 3'b000, 32'hFFFFFFF0, 1'b0});
        ld.push_back('{1'b0, 32'h8, 32'h0, 3'b101, 32'h0000ABCD, 1'b0});
        sel0 = 1'b1;
        resp_pat = 6'b0; ready_pat = 6'b0; idx = 0;
        @(posedge clk); #1;
        req_we = ld[0].we; req_addr = ld[0].addr; req_wdata = ld[0].wdata; req_funct3 = ld[0].f3;
        exp_q.push_back({ld[0].exp_err, ld[0].exp_rd});
        rv0 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            resp_pat  = {resp_pat[4:0], resp_valid0};
            ready_pat = {ready_pat[4:0], ready0};
            if (resp_valid0) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata0 !== e.rd || err0 !== e.err) begin
                    failures++;
                    $display("FAIL b2b_load[%0d] rdata=%h err=%b required %h/%b", idx, rdata0, err0, e.rd, e.err);
                end
                idx++;
                @(posedge clk); #1;
                if (idx < 3) begin
                    req_we = ld[idx].we; req_addr = ld[idx].addr; req_wdata = ld[idx].wdata; req_funct3 = ld[idx].f3;
                    exp_q.push_back({ld[idx].exp_err, ld[idx].exp_rd});
                end else begin
                    rv0 = 1'b0;
                end
            end
        end
        rv0 = 1'b0;
        checks++;
        if (resp_pat !== 6'b010101 || ready_pat !== 6'b101010) begin
            failures++;
            $display("FAIL b2b_pattern resp=%b ready=%b required 010101/101010", resp_pat, ready_pat);
        end
        checks++;
        if (idx != 3) begin
            failures++;
            $display("FAIL b2b_count responses=%0d required 3", idx);
        end
        exp_q.delete();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
